// File: rtl/smem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smem_arb_pkg
// Description : Shared types and constants for the RC4 S-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package smem_arb_pkg;

    localparam int SEL_W = 8;

    localparam int REQ_INIT = 0;
    localparam int REQ_KSA  = 1;
    localparam int REQ_PRGA = 2;
    localparam int REQ_CTRL = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/smem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : smem_arb_pick
// Description : Combinational winner selection for the S-memory arbiter.
//               SMEM_ARB_ROUND_ROBIN_EN selects round-robin from i_start;
//               otherwise the highest-index active request wins.
// Revision    : 1.0 - initial release
// ============================================================================
module smem_arb_pick #(
    parameter int NUM_REQ = 7
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [2:0]         i_start,
    output logic [NUM_REQ-1:0] o_win,
    output logic [2:0]         o_idx
);

`ifdef SMEM_ARB_ROUND_ROBIN_EN
    int   w_pos;
    logic w_found;

    // Scan from the start pointer and wrap; the first active request wins.
    always_comb begin
        o_win   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(i_start) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_win[w_pos] = 1'b1;
                o_idx        = 3'(w_pos);
            end
        end
    end
`else
    logic w_unused_start;
    assign w_unused_start = ^i_start;

    // Later iterations overwrite earlier ones, so the highest index wins.
    always_comb begin
        o_win = '0;
        o_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req[k]) begin
                o_win    = '0;
                o_win[k] = 1'b1;
                o_idx    = 3'(k);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/smem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : smem_access_arbiter
// Description : Arbitrates the single-port RC4 S-memory between requester
//               FSMs; grants are atomic, bounded by MAX_HOLD, and separated
//               by one idle-bus cycle. Macro: SMEM_ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module smem_access_arbiter #(
    parameter int NUM_REQ  = 7,
    parameter int SEL_W    = smem_arb_pkg::SEL_W,
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   mux_sel,
    output logic               busy,
    output logic [NUM_REQ-1:0] preempt,
    output logic [2:0]         last_owner
);
    import smem_arb_pkg::*;

    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [2:0]        C_LAST_RST  = 3'(NUM_REQ - 1);

    arb_state_t         r_state;
    logic [HOLD_W-1:0]  r_hold;
    logic [NUM_REQ-1:0] r_gnt;
    logic [SEL_W-1:0]   r_mux_sel;
    logic               r_busy;
    logic [NUM_REQ-1:0] r_preempt;
    logic [2:0]         r_last_owner;

    logic [NUM_REQ-1:0] w_win;
    logic [2:0]         w_win_idx;
    logic               w_owner_req;

    smem_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req   (req),
        .i_start (r_last_owner + 3'd1 == 3'(NUM_REQ) ? 3'd0 : r_last_owner + 3'd1),
        .o_win   (w_win),
        .o_idx   (w_win_idx)
    );

    // While granted, last_owner is the current owner.
    assign w_owner_req = req[r_last_owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_gnt        <= '0;
            r_mux_sel    <= '0;
            r_busy       <= 1'b0;
            r_preempt    <= '0;
            r_last_owner <= C_LAST_RST;
        end else begin
            r_preempt <= '0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state      <= GRANT;
                        r_gnt        <= w_win;
                        r_mux_sel    <= SEL_W'(w_win);
                        r_busy       <= 1'b1;
                        r_last_owner <= w_win_idx;
                        r_hold       <= '0;
                    end
                end
                GRANT: begin
                    if (!w_owner_req || r_hold == C_HOLD_LAST) begin
                        r_state   <= GAP;
                        r_gnt     <= '0;
                        r_mux_sel <= '0;
                        r_busy    <= 1'b0;
                        // A release on the final cycle is normal, not preemption.
                        if (w_owner_req) begin
                            r_preempt <= r_gnt;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign mux_sel    = r_mux_sel;
    assign busy       = r_busy;
    assign preempt    = r_preempt;
    assign last_owner = r_last_owner;

endmodule
`default_nettype wire

// File: doc/smem_access_arbiter.md
Name: smem_access_arbiter

Overview:
- Shares the single-port RC4 S-memory (address/data/wren) between up to seven requesting FSMs: S-init, KSA swap, PRGA decrypt, key-search control, and similar.
- Sits in front of the 8-way one-hot select mux that steers memory-bus signals.
- Produces that mux's select vector plus per-requester grant signals.
- Select all-zero routes the default/idle source, which drives wren=0.

Parameters:
- NUM_REQ, 7, number of requesters (1..7); requester i maps to select bit i.
- SEL_W, 8, width of the select vector driven to the mux.
- MAX_HOLD, 64, maximum consecutive cycles one grant may be held before forced release.
- HOLD_W, 7, counter width; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  request per requester; level-held for the whole transaction
- gnt  out  NUM_REQ  one-hot grant; at most one bit set
- mux_sel  out  SEL_W  one-hot mux select; bit i = gnt[i]; bits NUM_REQ..SEL_W-1 are always 0
- busy  out  1  high while any grant is active
- preempt  out  NUM_REQ  one-cycle pulse: requester i lost its grant due to MAX_HOLD
- last_owner  out  3  index of the most recent grantee; round-robin pointer source

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; gnt=0; mux_sel=0; busy=0; preempt=0; last_owner=NUM_REQ-1; hold counter=0. So the first round-robin search starts at requester 0.
- All outputs are registered. mux_sel and gnt change only on the rising edge of clk.
- State IDLE:
  - If any req bit is set, pick the winner. The search starts at (last_owner+1) mod NUM_REQ and wraps.
  - Next cycle: state=GRANT, gnt[winner]=1, last_owner=winner, hold counter=0.
  - Latency from req rise to gnt is 1 cycle.
- State GRANT:
  - The hold counter increments each cycle while req[owner]=1.
  - Normal release: if req[owner]=0, then next cycle state=GAP and gnt=0.
  - Forced release: if the counter reaches MAX_HOLD-1 with req still high, then next cycle state=GAP, gnt=0, and preempt[owner] pulses for 1 cycle.
  - Requests from other requesters are ignored while in GRANT (no mid-transaction switch). This keeps KSA read-swap-write sequences atomic.
- State GAP:
  - Exactly one cycle with mux_sel=0, so the idle source drives wren=0 and no bus contention occurs between owners.
  - Next cycle the block returns to IDLE, and arbitration happens in that IDLE cycle.
  - Back-to-back owner switch costs 3 cycles from req drop to the new gnt.
- A preempted requester that keeps req high is eligible again, but only in its round-robin turn.
- busy=1 in GRANT, 0 otherwise.
- Boundary behaviour:
  - req bits at or above NUM_REQ are ignored.
  - If only one requester is active, it is re-granted after each GAP.
  - If req[owner] drops on the same cycle the counter hits MAX_HOLD-1, treat it as a normal release; preempt stays 0.
  - If rst_n is asserted mid-grant, gnt drops immediately (asynchronously); the requester FSM must restart its transaction.
  - With req=0 the block stays in IDLE indefinitely with mux_sel=0.

Optional Feature:
- Macro: SMEM_ARB_ROUND_ROBIN_EN.
- Defined: arbitration is round-robin as described above.
- Undefined: fixed priority; the highest-index active req wins. last_owner is still updated but not used for selection.
- Undefined is the default. It gives the decrypt/control FSM at the top index precedence over the init FSM at index 0.

Decomposition:
- Package smem_arb_pkg holds:
  - the state enum (IDLE, GRANT, GAP)
  - SEL_W
  - the requester index constants: REQ_INIT=0, REQ_KSA=1, REQ_PRGA=2, REQ_CTRL=3
- One sub-module: smem_arb_pick.
  - Purely combinational winner selection.
  - Inputs: req and start pointer.
  - Outputs: one-hot winner and its index.
  - Contains both the round-robin and the fixed-priority variants under the macro.

Test Plan:
- Reset, single request: assert rst_n low then high, then set req=0000001 -> gnt=0000001 and mux_sel=8'h01 one cycle later; busy=1. After req drops, gnt=0 and mux_sel=0.
- Atomic hold: hold req[1] for 10 cycles while raising req[2] in cycle 3 -> gnt[1] stays set for all 10 cycles; after 1 GAP cycle and 1 IDLE cycle, gnt=0000100.
- Round-robin fairness (macro defined): hold req=0000111 continuously with each owner releasing after 2 cycles -> grant order 0,1,2,0,1,2.
- Fixed priority (macro undefined): same stimulus -> requester 2 wins every time; after req[2] drops, requester 1 wins.
- Preemption: MAX_HOLD=8, hold req[3] high -> preempt[3] pulses exactly once after 8 grant cycles, then a GAP follows, then re-grant when no other req is pending.
- Reset mid-grant: drive rst_n low while gnt[2]=1 -> gnt, mux_sel and busy go to 0 without waiting for a clk edge; after release the next grant goes to requester 0 under round-robin.
